// File: rtl/ram_port_arbiter_if.sv
//------------------------------------------------------------------------------
// ram_port_arbiter_if : CPU, secondary-master and RAM macro signals of the arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ram_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          CPU_EN;
  logic          CPU_WE;
  logic [1:0]    CPU_BE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_WAIT;

  logic          DMA_REQ;
  logic          DMA_WE;
  logic [1:0]    DMA_BE;
  logic [AW-1:0] DMA_ADDR;
  logic [DW-1:0] DMA_WDATA;
  logic          DMA_ACK;
  logic [DW-1:0] DMA_RDATA;
  logic          DMA_RVALID;

  logic          RAM_EN;
  logic          RAM_WE;
  logic [1:0]    RAM_BE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DATA;
  logic [DW-1:0] RAM_Q;

  // Environment side: CPU path, secondary master and the RAM macro.
  modport master (
    output CPU_EN, CPU_WE, CPU_BE, CPU_ADDR, CPU_WDATA,
    input  CPU_WAIT,
    output DMA_REQ, DMA_WE, DMA_BE, DMA_ADDR, DMA_WDATA,
    input  DMA_ACK, DMA_RDATA, DMA_RVALID,
    input  RAM_EN, RAM_WE, RAM_BE, RAM_ADDR, RAM_DATA,
    output RAM_Q
  );

  modport slave (
    input  CPU_EN, CPU_WE, CPU_BE, CPU_ADDR, CPU_WDATA,
    output CPU_WAIT,
    input  DMA_REQ, DMA_WE, DMA_BE, DMA_ADDR, DMA_WDATA,
    output DMA_ACK, DMA_RDATA, DMA_RVALID,
    output RAM_EN, RAM_WE, RAM_BE, RAM_ADDR, RAM_DATA,
    input  RAM_Q
  );
endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// ram_port_arbiter : CPU-priority sharing of the MCU RAM with a secondary master.
// Optional starvation guard: define RAM_ARB_STARVE_EN.  Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic           CLK,
  input  wire logic           RESET,
  ram_port_arbiter_if.slave   bus
);

  logic          force_grant;
  logic          dma_own;
  logic          ram_en;
  logic          ram_we;
  logic [1:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;

  logic          rd_pend_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  if (STARVE_LIMIT < 1) begin : g_limit_invalid
  end

  // The secondary master is never granted while reset is held.
  always_comb begin
    dma_own  = ~RESET & bus.DMA_REQ & (~bus.CPU_EN | force_grant);
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_be   = 2'b00;
    ram_addr = bus.CPU_ADDR;
    ram_data = bus.CPU_WDATA;
    if (dma_own) begin
      ram_en   = 1'b1;
      ram_we   = bus.DMA_WE;
      ram_be   = bus.DMA_BE;
      ram_addr = bus.DMA_ADDR;
      ram_data = bus.DMA_WDATA;
    end else if (bus.CPU_EN) begin
      ram_en   = 1'b1;
      ram_we   = bus.CPU_WE;
      ram_be   = bus.CPU_BE;
    end
  end

  assign bus.RAM_EN   = ram_en;
  assign bus.RAM_WE   = ram_we;
  assign bus.RAM_BE   = ram_be;
  assign bus.RAM_ADDR = ram_addr;
  assign bus.RAM_DATA = ram_data;
  assign bus.DMA_ACK  = dma_own;

  // RAM Q carries the read one cycle after issue; capture it the cycle after that.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rd_pend_q <= dma_own & ~bus.DMA_WE;
      rvalid_q  <= rd_pend_q;
      if (rd_pend_q) begin
        rdata_q <= bus.RAM_Q;
      end
    end
  end

  assign bus.DMA_RDATA  = rdata_q;
  assign bus.DMA_RVALID = rvalid_q;

`ifdef RAM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          wait_q;
  logic          wait_d;

  // wait_q marks the single forced-grant cycle that follows a saturated count.
  always_comb begin
    starve_d = starve_q;
    if (!bus.DMA_REQ || dma_own) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
    wait_d = bus.DMA_REQ & ~dma_own & (starve_d == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_q <= '0;
      wait_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      wait_q   <= wait_d;
    end
  end

  assign force_grant  = wait_q & bus.DMA_REQ;
  assign bus.CPU_WAIT = wait_q;
`else
  assign force_grant  = 1'b0;
  assign bus.CPU_WAIT = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_ram_port_arbiter : directed self-checking bench with a registered-output RAM model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ram_port_arbiter_if #(.AW(12), .DW(16)) bus ();

  ram_port_arbiter #(.AW(12), .DW(16), .STARVE_LIMIT(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Single-port RAM, byte enables, read-first, one-cycle registered Q.
  logic [15:0] mem [0:4095];
  logic [15:0] ram_q;

  always @(posedge clk) begin
    if (bus.RAM_EN) begin
      if (bus.RAM_WE && bus.RAM_BE[0]) mem[bus.RAM_ADDR][7:0]  <= bus.RAM_DATA[7:0];
      if (bus.RAM_WE && bus.RAM_BE[1]) mem[bus.RAM_ADDR][15:8] <= bus.RAM_DATA[15:8];
      ram_q <= mem[bus.RAM_ADDR];
    end
  end
  assign bus.RAM_Q = ram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.CPU_EN    = 1'b0;
    bus.CPU_WE    = 1'b0;
    bus.CPU_BE    = 2'b00;
    bus.CPU_ADDR  = 12'h000;
    bus.CPU_WDATA = 16'h0000;
    bus.DMA_REQ   = 1'b0;
    bus.DMA_WE    = 1'b0;
    bus.DMA_BE    = 2'b00;
    bus.DMA_ADDR  = 12'h000;
    bus.DMA_WDATA = 16'h0000;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
    idle();
    bus.CPU_EN = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_BE = 2'b11;
    bus.CPU_ADDR = a; bus.CPU_WDATA = d;
    step();
    idle();
  endtask

  task automatic dma_set(input logic we, input logic [1:0] be, input logic [11:0] a,
                         input logic [15:0] d);
    bus.DMA_REQ = 1'b1; bus.DMA_WE = we; bus.DMA_BE = be;
    bus.DMA_ADDR = a; bus.DMA_WDATA = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    dma_set(1'b0, 2'b11, 12'h005, 16'h0000);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.DMA_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.DMA_ACK); end
      checks++; if (bus.DMA_RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", bus.DMA_RVALID); end
      checks++; if (bus.CPU_WAIT !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b exp=0", bus.CPU_WAIT); end
      checks++; if (bus.RAM_EN !== 1'b0) begin errors++; $display("FAIL reset_ram_en got=%b exp=0", bus.RAM_EN); end
      step();
    end
    checks++; if (bus.DMA_RDATA !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", bus.DMA_RDATA); end
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_dma_write_read();
    dma_set(1'b1, 2'b11, 12'h005, 16'h1234);
    #1;
    checks++; if (bus.DMA_ACK !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", bus.DMA_ACK); end
    checks++; if ({bus.RAM_EN, bus.RAM_WE, bus.RAM_BE} !== 4'b1111) begin errors++; $display("FAIL wr_ctrl got=%b exp=1111", {bus.RAM_EN, bus.RAM_WE, bus.RAM_BE}); end
    checks++; if (bus.RAM_ADDR !== 12'h005 || bus.RAM_DATA !== 16'h1234) begin errors++; $display("FAIL wr_addr_data got=%h/%h exp=005/1234", bus.RAM_ADDR, bus.RAM_DATA); end
    step();
    dma_set(1'b0, 2'b11, 12'h005, 16'h0000);
    #1;
    checks++; if (bus.DMA_ACK !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", bus.DMA_ACK); end
    step();
    idle();
    #1;
    checks++; if (bus.DMA_RVALID !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early got=%b exp=0", bus.DMA_RVALID); end
    checks++; if (bus.DMA_ACK !== 1'b0) begin errors++; $display("FAIL rd_ack_drop got=%b exp=0", bus.DMA_ACK); end
    step();
    checks++; if (bus.DMA_RVALID !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", bus.DMA_RVALID); end
    checks++; if (bus.DMA_RDATA !== 16'h1234) begin errors++; $display("FAIL rd_data got=%h exp=1234", bus.DMA_RDATA); end
    step();
    checks++; if (bus.DMA_RVALID !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got=%b exp=0", bus.DMA_RVALID); end
  endtask

  task automatic test_byte_write();
    cpu_write(12'h010, 16'hFFFF);
    dma_set(1'b1, 2'b01, 12'h010, 16'hAB55);
    step();
    dma_set(1'b0, 2'b11, 12'h010, 16'h0000);
    step();
    idle();
    step();
    checks++; if (bus.DMA_RVALID !== 1'b1 || bus.DMA_RDATA !== 16'hFF55) begin errors++; $display("FAIL byte_write got=%b/%h exp=1/ff55", bus.DMA_RVALID, bus.DMA_RDATA); end
    step();
  endtask

  task automatic test_be_zero();
    dma_set(1'b1, 2'b00, 12'h005, 16'h9999);
    #1;
    checks++; if ({bus.DMA_ACK, bus.RAM_EN, bus.RAM_WE, bus.RAM_BE} !== 5'b11100) begin errors++; $display("FAIL be0_ctrl got=%b exp=11100", {bus.DMA_ACK, bus.RAM_EN, bus.RAM_WE, bus.RAM_BE}); end
    step();
    dma_set(1'b0, 2'b11, 12'h005, 16'h0000);
    step();
    idle();
    step();
    checks++; if (bus.DMA_RVALID !== 1'b1 || bus.DMA_RDATA !== 16'h1234) begin errors++; $display("FAIL be0_data got=%b/%h exp=1/1234", bus.DMA_RVALID, bus.DMA_RDATA); end
    step();
  endtask

  task automatic test_contention();
    idle();
    bus.CPU_EN = 1'b1; bus.CPU_ADDR = 12'h030;
    dma_set(1'b1, 2'b11, 12'h040, 16'h4444);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.DMA_ACK !== 1'b0) begin errors++; $display("FAIL cont_ack cyc=%0d got=%b exp=0", i, bus.DMA_ACK); end
      checks++; if (bus.RAM_ADDR !== 12'h030) begin errors++; $display("FAIL cont_addr cyc=%0d got=%h exp=030", i, bus.RAM_ADDR); end
      checks++; if (bus.CPU_WAIT !== 1'b0) begin errors++; $display("FAIL cont_wait cyc=%0d got=%b exp=0", i, bus.CPU_WAIT); end
      step();
    end
    bus.CPU_EN = 1'b0;
    #1;
    checks++; if (bus.DMA_ACK !== 1'b1 || bus.RAM_ADDR !== 12'h040) begin errors++; $display("FAIL cont_release got=%b/%h exp=1/040", bus.DMA_ACK, bus.RAM_ADDR); end
    step();
    bus.DMA_REQ = 1'b0;
    #1;
    checks++; if ({bus.RAM_EN, bus.RAM_WE, bus.RAM_BE} !== 4'b0000 || bus.RAM_ADDR !== 12'h030) begin errors++; $display("FAIL idle_mux got=%b/%h exp=0000/030", {bus.RAM_EN, bus.RAM_WE, bus.RAM_BE}, bus.RAM_ADDR); end
    step();
    idle();
  endtask

  task automatic test_interleave();
    cpu_write(12'h020, 16'h0BEE);
    cpu_write(12'h021, 16'hCAFE);
    dma_set(1'b0, 2'b11, 12'h020, 16'h0000);
    #1;
    checks++; if (bus.DMA_ACK !== 1'b1) begin errors++; $display("FAIL il_ack got=%b exp=1", bus.DMA_ACK); end
    step();
    idle();
    bus.CPU_EN = 1'b1; bus.CPU_ADDR = 12'h021;
    #1;
    checks++; if (bus.RAM_Q !== 16'h0BEE || bus.RAM_ADDR !== 12'h021) begin errors++; $display("FAIL il_n1 got=%h/%h exp=0bee/021", bus.RAM_Q, bus.RAM_ADDR); end
    checks++; if (bus.DMA_RVALID !== 1'b0) begin errors++; $display("FAIL il_n1_rvalid got=%b exp=0", bus.DMA_RVALID); end
    step();
    idle();
    #1;
    checks++; if (bus.RAM_Q !== 16'hCAFE) begin errors++; $display("FAIL il_n2_q got=%h exp=cafe", bus.RAM_Q); end
    checks++; if (bus.DMA_RVALID !== 1'b1 || bus.DMA_RDATA !== 16'h0BEE) begin errors++; $display("FAIL il_n2_rdata got=%b/%h exp=1/0bee", bus.DMA_RVALID, bus.DMA_RDATA); end
    step();
  endtask

  task automatic test_back_to_back();
    dma_set(1'b0, 2'b11, 12'h021, 16'h0000);
    #1;
    checks++; if (bus.DMA_ACK !== 1'b1) begin errors++; $display("FAIL b2b_ack0 got=%b exp=1", bus.DMA_ACK); end
    step();
    dma_set(1'b0, 2'b11, 12'h020, 16'h0000);
    #1;
    checks++; if (bus.DMA_ACK !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got=%b exp=1", bus.DMA_ACK); end
    step();
    idle();
    #1;
    checks++; if (bus.DMA_RVALID !== 1'b1 || bus.DMA_RDATA !== 16'hCAFE) begin errors++; $display("FAIL b2b_rd0 got=%b/%h exp=1/cafe", bus.DMA_RVALID, bus.DMA_RDATA); end
    step();
    checks++; if (bus.DMA_RVALID !== 1'b1 || bus.DMA_RDATA !== 16'h0BEE) begin errors++; $display("FAIL b2b_rd1 got=%b/%h exp=1/0bee", bus.DMA_RVALID, bus.DMA_RDATA); end
    step();
    checks++; if (bus.DMA_RVALID !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", bus.DMA_RVALID); end
  endtask

  task automatic test_reset_midread();
    dma_set(1'b0, 2'b11, 12'h020, 16'h0000);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.DMA_RVALID !== 1'b0) begin errors++; $display("FAIL midread_rvalid cyc=%0d got=%b exp=0", i, bus.DMA_RVALID); end
      step();
    end
  endtask

  task automatic test_starve();
    idle();
    bus.CPU_EN = 1'b1; bus.CPU_ADDR = 12'h030;
    dma_set(1'b1, 2'b11, 12'h050, 16'h5A5A);
`ifdef RAM_ARB_STARVE_EN
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++; if (bus.DMA_ACK !== 1'b0 || bus.CPU_WAIT !== 1'b0) begin errors++; $display("FAIL starve_pre cyc=%0d got=%b%b exp=00", i, bus.DMA_ACK, bus.CPU_WAIT); end
      step();
    end
    #1;
    checks++; if (bus.DMA_ACK !== 1'b1 || bus.CPU_WAIT !== 1'b1) begin errors++; $display("FAIL starve_force got=%b%b exp=11", bus.DMA_ACK, bus.CPU_WAIT); end
    checks++; if (bus.RAM_ADDR !== 12'h050) begin errors++; $display("FAIL starve_addr got=%h exp=050", bus.RAM_ADDR); end
    step();
    bus.DMA_REQ = 1'b0;
    #1;
    checks++; if (bus.DMA_ACK !== 1'b0 || bus.CPU_WAIT !== 1'b0 || bus.RAM_ADDR !== 12'h030) begin errors++; $display("FAIL starve_after got=%b%b/%h exp=00/030", bus.DMA_ACK, bus.CPU_WAIT, bus.RAM_ADDR); end
    step();
`else
    for (int i = 1; i <= 12; i++) begin
      #1;
      checks++; if (bus.DMA_ACK !== 1'b0 || bus.CPU_WAIT !== 1'b0) begin errors++; $display("FAIL starve_none cyc=%0d got=%b%b exp=00", i, bus.DMA_ACK, bus.CPU_WAIT); end
      step();
    end
`endif
    idle();
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle();
    test_reset();
    test_dma_write_read();
    test_byte_write();
    test_be_zero();
    test_contention();
    test_interleave();
    test_back_to_back();
    test_reset_midread();
    test_starve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
